// File: rtl/bram_dp.sv
// bram_dp: dual-port byte-writable block RAM; port A fetch-only, port B load/store.
// Define BRAM_OUTREG_EN to add an output register stage on both ports (2-cycle latency).
module bram_dp #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 1024,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter     INIT_FILE = ""
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                a_en,
  input  logic [ADDR_W-1:0]   a_addr,
  output logic [DATA_W-1:0]   a_data,
  output logic                a_valid,
  input  logic                b_en,
  input  logic [DATA_W/8-1:0] b_we,
  input  logic [ADDR_W-1:0]   b_addr,
  input  logic [DATA_W-1:0]   b_wdata,
  output logic [DATA_W-1:0]   b_rdata,
  output logic                b_valid,
  output logic                b_err
);
  localparam int NB = DATA_W / 8;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              a_ok, b_ok, b_rd;
  logic [DATA_W-1:0] a_q, b_q;
  logic              a_v, b_v, e_v;
  always_comb begin
    a_ok = 32'(a_addr) < DEPTH;
    b_ok = 32'(b_addr) < DEPTH;
    b_rd = b_en && b_we == '0;
  end
  // Memory has no reset; writes in a reset cycle are dropped like any other request.
  always_ff @(posedge clk) begin
    if (!reset && b_en && b_ok)
      for (int i = 0; i < NB; i++)
        if (b_we[i]) mem[b_addr][8*i +: 8] <= b_wdata[8*i +: 8];
  end
  // Nonblocking reads of mem give read-first behaviour on A/B collisions.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q <= '0;
      b_q <= '0;
      a_v <= 1'b0;
      b_v <= 1'b0;
      e_v <= 1'b0;
    end else begin
      a_v <= a_en;
      b_v <= b_rd;
      e_v <= b_en && !b_ok;
      if (a_en) a_q <= a_ok ? mem[a_addr] : '0;
      if (b_rd) b_q <= b_ok ? mem[b_addr] : '0;
    end
  end
`ifdef BRAM_OUTREG_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      a_data  <= '0;
      b_rdata <= '0;
      a_valid <= 1'b0;
      b_valid <= 1'b0;
      b_err   <= 1'b0;
    end else begin
      a_valid <= a_v;
      b_valid <= b_v;
      b_err   <= e_v;
      if (a_v) a_data <= a_q;
      if (b_v) b_rdata <= b_q;
    end
  end
`else
  always_comb begin
    a_data  = a_q;
    b_rdata = b_q;
    a_valid = a_v;
    b_valid = b_v;
    b_err   = e_v;
  end
`endif
endmodule

// File: tb/tb_bram_dp.sv
// tb_bram_dp: scoreboard bench for bram_dp with DEPTH=1000 (non-power-of-two range checks).
module tb_bram_dp;
`ifdef BRAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int DEPTH = 1000;
  typedef struct {
    int          due;
    logic        vld;
    logic        err;
    logic [31:0] d;
  } exp_t;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        a_en = 1'b0, b_en = 1'b0;
  logic [9:0]  a_addr = '0, b_addr = '0;
  logic [3:0]  b_we = '0;
  logic [31:0] b_wdata = '0;
  logic [31:0] a_data, b_rdata;
  logic        a_valid, b_valid, b_err;
  logic [31:0] mdl [1024];
  exp_t        qa[$], qb[$];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  bram_dp #(.DATA_W(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .a_en(a_en), .a_addr(a_addr), .a_data(a_data), .a_valid(a_valid),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(b_rdata), .b_valid(b_valid), .b_err(b_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    exp_t e;
    if (qa.size() > 0 && qa[0].due == cyc) begin
      e = qa.pop_front();
      total++;
      if (a_valid !== 1'b1 || a_data !== e.d) begin
        bad++;
        $display("FAIL a_read cyc=%0d got valid=%b data=%h want valid=1 data=%h", cyc, a_valid, a_data, e.d);
      end
    end else if (a_valid === 1'b1) begin
      total++;
      bad++;
      $display("FAIL a_spurious cyc=%0d got valid=1 data=%h want valid=0", cyc, a_data);
    end
    if (qb.size() > 0 && qb[0].due == cyc) begin
      e = qb.pop_front();
      total++;
      if (b_valid !== e.vld || b_err !== e.err || (e.vld && b_rdata !== e.d)) begin
        bad++;
        $display("FAIL b_resp cyc=%0d got valid=%b err=%b data=%h want valid=%b err=%b data=%h",
                 cyc, b_valid, b_err, b_rdata, e.vld, e.err, e.d);
      end
    end else if (b_valid === 1'b1 || b_err === 1'b1) begin
      total++;
      bad++;
      $display("FAIL b_spurious cyc=%0d got valid=%b err=%b want 0 0", cyc, b_valid, b_err);
    end
  end

  task automatic step(input logic ae, input logic [9:0] aa, input logic be,
                      input logic [3:0] bw, input logic [9:0] ba, input logic [31:0] bd);
    logic oor;
    @(negedge clk);
    a_en = ae; a_addr = aa; b_en = be; b_we = bw; b_addr = ba; b_wdata = bd;
    if (ae) qa.push_back(exp_t'{cyc + LAT, 1'b1, 1'b0, (32'(aa) < DEPTH) ? mdl[aa] : 32'h0});
    if (be) begin
      oor = 32'(ba) >= DEPTH;
      if (bw == 4'h0) qb.push_back(exp_t'{cyc + LAT, 1'b1, oor, oor ? 32'h0 : mdl[ba]});
      else if (oor) qb.push_back(exp_t'{cyc + LAT, 1'b0, 1'b1, 32'h0});
      else for (int i = 0; i < 4; i++) if (bw[i]) mdl[ba][8*i +: 8] = bd[8*i +: 8];
    end
  endtask

  task automatic drain(input string name);
    step(1'b0, '0, 1'b0, '0, '0, '0);
    for (int i = 0; i < 10 && (qa.size() > 0 || qb.size() > 0); i++) @(negedge clk);
    total++;
    if (qa.size() > 0 || qb.size() > 0) begin
      bad++;
      $display("FAIL %s_timeout got pending a=%0d b=%0d want 0 0", name, qa.size(), qb.size());
      qa.delete();
      qb.delete();
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({a_data, b_rdata, a_valid, b_valid, b_err} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got a=%h b=%h av=%b bv=%b err=%b want all 0", a_data, b_rdata, a_valid, b_valid, b_err);
    end
    reset = 1'b0;
  endtask

  task automatic test_preload;
    for (int k = 0; k < 16; k++) step(1'b0, '0, 1'b1, 4'hF, 10'(k), 32'(k));
    drain("preload");
  endtask

  task automatic test_seq_read;
    for (int k = 0; k < 5; k++) step(1'b1, 10'(k), 1'b0, '0, '0, '0);
    drain("seq_read");
  endtask

  task automatic test_byte_we;
    step(1'b0, '0, 1'b1, 4'hF, 10'd7, 32'h11223344);
    step(1'b0, '0, 1'b1, 4'b0101, 10'd7, 32'hAABBCCDD);
    step(1'b0, '0, 1'b1, 4'h0, 10'd7, '0);
    drain("byte_we");
    total++;
    if (mdl[7] !== 32'h11BB33DD) begin
      bad++;
      $display("FAIL byte_we_model got %h want 11bb33dd", mdl[7]);
    end
  endtask

  task automatic test_back_to_back;
    step(1'b0, '0, 1'b1, 4'hF, 10'd9, 32'hCAFEF00D);
    step(1'b0, '0, 1'b1, 4'h0, 10'd9, '0);
    step(1'b0, '0, 1'b1, 4'b1000, 10'd9, 32'h5A000000);
    step(1'b0, '0, 1'b1, 4'h0, 10'd9, '0);
    drain("back_to_back");
  endtask

  task automatic test_collision;
    step(1'b1, 10'd3, 1'b1, 4'hF, 10'd3, 32'hDEADBEEF);
    step(1'b1, 10'd3, 1'b0, '0, '0, '0);
    drain("collision");
  endtask

  task automatic test_out_of_range;
    step(1'b0, '0, 1'b1, 4'h0, 10'd1000, '0);
    step(1'b0, '0, 1'b1, 4'hF, 10'd1020, 32'h12345678);
    step(1'b1, 10'd1020, 1'b1, 4'h0, 10'd1020, '0);
    step(1'b1, 10'd999, 1'b1, 4'h0, 10'd4, '0);
    drain("out_of_range");
  endtask

  task automatic test_b_disabled;
    step(1'b0, '0, 1'b0, 4'hF, 10'd5, 32'hFFFFFFFF);
    step(1'b1, 10'd5, 1'b1, 4'h0, 10'd5, '0);
    drain("b_disabled");
  endtask

  task automatic test_random;
    for (int n = 0; n < 60; n++)
      step(1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(0, 15)),
           10'($urandom_range(0, 15)), $urandom);
    drain("random");
  endtask

  task automatic test_reset_drop;
    @(negedge clk);
    reset = 1'b1;
    a_en = 1'b1; a_addr = 10'd7; b_en = 1'b1; b_we = 4'hF; b_addr = 10'd7; b_wdata = 32'h0BADF00D;
    @(negedge clk);
    a_en = 1'b0; b_en = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({a_data, b_rdata, a_valid, b_valid, b_err} !== '0) begin
      bad++;
      $display("FAIL reset_drop got a=%h b=%h av=%b bv=%b err=%b want all 0", a_data, b_rdata, a_valid, b_valid, b_err);
    end
`ifdef BRAM_OUTREG_EN
    @(negedge clk);
    a_en = 1'b1; a_addr = 10'd7;
    @(negedge clk);
    a_en = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({a_data, a_valid} !== '0) begin
      bad++;
      $display("FAIL reset_pipe got a=%h av=%b want 0 0", a_data, a_valid);
    end
`endif
    step(1'b1, 10'd7, 1'b1, 4'h0, 10'd3, '0);
    drain("post_reset");
  endtask

  initial begin
    test_reset;
    test_preload;
    test_seq_read;
    test_byte_we;
    test_back_to_back;
    test_collision;
    test_out_of_range;
    test_b_disabled;
    test_random;
    test_reset_drop;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
